alu_serial_ctrl: RTL and testbench
==================================

Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer that computes a WIDTH-bit ALU operation by reusing one external 1-bit ALU slice for WIDTH consecutive cycles, LSB first.
- Latches the operands on start, drives the slice's inputs each cycle, and carries the slice's cout forward as the next cin.
- Assembles the result in a shift register and reports done, cout, overflow and zero.
- Sits between the instruction-level controller and the 1-bit slice. It trades area for a latency of WIDTH cycles.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new operation; sampled only in IDLE
inputA  input  WIDTH  operand A, latched when start is accepted
inputB  input  WIDTH  operand B, latched when start is accepted
sel  input  2  op: 00 AND, 01 OR, 10 ADD/SUB, 11 SLT; latched
binvert  input  1  1 = subtract (B inverted, cin=1); forced to 1 for SLT; latched
busy  output  1  operation in progress
done  output  1  one-cycle pulse: result valid
dataOut  output  WIDTH  result, held from done until next accepted start
cout  output  1  carry out of MSB (ADD/SUB); 0 for AND/OR/SLT
overflow  output  1  signed overflow (ADD/SUB); 0 otherwise
zero  output  1  dataOut == 0
slice_a  output  1  to slice inputA
slice_b  output  1  to slice inputB
slice_cin  output  1  to slice cin
slice_sel  output  2  to slice sel
slice_binvert  output  1  to slice binvert
slice_less  output  1  to slice less; always 0
slice_out  input  1  slice dataOut (combinational)
slice_cout  input  1  slice cout (combinational)

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low.
  - All registered outputs are 0 at reset: busy, done, dataOut, cout, overflow. zero therefore reads 1 at reset.
  - State goes to IDLE. Shift and carry registers go to 0.
- States: IDLE, RUN, SLT_FIX, DONE.
- IDLE:
  - On start=1: latch A/B into shift registers, latch op and binvert, set carry = binvert (1 for SLT), set bit counter = 0, go to RUN.
  - busy goes high on the next cycle.
- RUN, one bit per cycle:
  - slice_a = A_sr[0], slice_b = B_sr[0], slice_cin = carry.
  - slice_sel = 10 when op is SLT, else op. slice_binvert = latched binvert (1 for SLT).
  - At each edge: shift slice_out into result MSB (shift right), shift A/B right, carry <= slice_cout, counter++.
  - On counter = WIDTH-1, also capture cin_msb = carry (the carry into the MSB) and cout = slice_cout.
  - After WIDTH cycles go to DONE, or to SLT_FIX if op = SLT.
- SLT_FIX, one cycle:
  - Result <= {0…0, result[WIDTH-1] XOR ovf}, where ovf = cin_msb XOR cout.
  - Then clear cout and overflow to 0 and go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - dataOut, cout and overflow are updated from internal registers on entry.
  - overflow = cin_msb XOR cout for ADD/SUB, 0 for AND/OR/SLT.
  - Next state is IDLE.
- busy = 1 in RUN and SLT_FIX, 0 in IDLE and DONE.
- Latency, from the edge accepting start to done high: WIDTH+1 cycles for AND/OR/ADD/SUB, WIDTH+2 for SLT.
- Boundaries:
  - start while busy or in DONE is ignored, not queued.
  - Input changes after acceptance do not affect the running op.
  - Reset mid-operation aborts immediately. No done pulse; outputs are cleared.
  - Back-to-back: start may be asserted in the cycle after done and is accepted from IDLE.
  - AND/OR ignore carry; cout is forced to 0 for them.
  - Output registers do not change during RUN. dataOut keeps the previous result until DONE.

Decomposition:
- Shared include alu_defs.vh:
  - Op codes OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_SLT=2'b11.
  - FSM state encodings ST_IDLE, ST_RUN, ST_SLT_FIX, ST_DONE.
- One natural sub-module, alu_serial_shreg: WIDTH-bit right-shift register with parallel load, async active-low clear and shift-in bit. Instantiated three times (A, B, result).
- The counter, carry flop and FSM stay in alu_serial_ctrl.
- Bench connects the 1-bit slice to the slice_* ports.

Test Plan (WIDTH=8):
- ADD: A=8'h7F, B=8'h01, sel=10, binvert=0 -> done 9 cycles after start; dataOut=8'h80, cout=0, overflow=1, zero=0.
- SUB: A=8'h05, B=8'h07, sel=10, binvert=1 -> dataOut=8'hFE, cout=0, overflow=0; A=B=8'h33 -> dataOut=0, zero=1, cout=1.
- SLT: A=8'hFD (-3), B=8'h02 -> dataOut=8'h01 after 10 cycles; A=8'h7F, B=8'hFF (overflow case) -> dataOut=8'h00, cout=0, overflow=0.
- AND/OR: A=8'hC3, B=8'hA5 -> AND 8'h81, OR 8'hE7, cout=0, overflow=0; slice_sel equals op every RUN cycle.
- Start while busy: second start with other operands at cycle 3 -> ignored; first result unchanged; exactly one done pulse.
- Reset: assert rst_n=0 at RUN cycle 4 -> busy, done, dataOut all 0 immediately; no done pulse; a new start after release completes normally.

Source files
------------

// File: rtl/alu_serial_ctrl_pkg.sv
// Shared op codes, FSM states and the op-to-slice mapping for the bit-serial ALU sequencer.
package alu_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SLT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_SLT_FIX = 2'b10,
    ST_DONE    = 2'b11
  } state_e;

  // SLT runs the slice as a subtractor; the less-than bit is fixed up afterwards.
  function automatic op_e slice_op(input op_e op);
    return (op == OP_SLT) ? OP_ADD : op;
  endfunction

endpackage

// File: rtl/alu_serial_shreg.sv
// Right-shift register with parallel load (load wins over shift), MSB shift-in, async clear.
// Single-cycle update; no flow control, the owner decides when to load or shift.
module alu_serial_shreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             shift_i,
  input  logic             shift_in_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_val_i;
    end else if (shift_i) begin
      data_q <= {shift_in_i, data_q[WIDTH-1:1]};
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer driving an external 1-bit slice, LSB first; done after WIDTH+1 cycles (WIDTH+2 for SLT).
// start is only sampled in IDLE; starts while busy or in DONE are dropped, not queued.
module alu_serial_ctrl
  import alu_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic [1:0]       sel,
  input  logic             binvert,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [1:0]       slice_sel,
  output logic             slice_binvert,
  output logic             slice_less,
  input  logic             slice_out,
  input  logic             slice_cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cin_msb_q;
  logic             cout_int_q;
  op_e              op_q;
  logic             binv_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] dout_q;
  logic             cout_q;
  logic             ovf_q;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_shift_d;
  logic [WIDTH-1:0] res_fix_d;
  logic             accept;
  logic             run;
  logic             fix;
  logic             last_bit;
  logic             slt_req;

  assign accept   = (state_q == ST_IDLE) && start;
  assign run      = (state_q == ST_RUN);
  assign fix      = (state_q == ST_SLT_FIX);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign slt_req  = (sel == OP_SLT);

  // Value the result register takes at this edge, so dataOut can be loaded in the same cycle.
  assign res_shift_d = {slice_out, res_sr[WIDTH-1:1]};
  assign res_fix_d   = {{(WIDTH-1){1'b0}}, res_sr[WIDTH-1] ^ cin_msb_q ^ cout_int_q};

  alu_serial_shreg #(.WIDTH(WIDTH)) u_a_sr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .load_val_i (inputA),
    .shift_i    (run),
    .shift_in_i (1'b0),
    .q_o        (a_sr)
  );

  alu_serial_shreg #(.WIDTH(WIDTH)) u_b_sr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .load_val_i (inputB),
    .shift_i    (run),
    .shift_in_i (1'b0),
    .q_o        (b_sr)
  );

  alu_serial_shreg #(.WIDTH(WIDTH)) u_res_sr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (fix),
    .load_val_i (res_fix_d),
    .shift_i    (run),
    .shift_in_i (slice_out),
    .q_o        (res_sr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      cin_msb_q  <= 1'b0;
      cout_int_q <= 1'b0;
      op_q       <= OP_AND;
      binv_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dout_q     <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= op_e'(sel);
            binv_q  <= binvert | slt_req;
            carry_q <= binvert | slt_req;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            cin_msb_q  <= carry_q;
            cout_int_q <= slice_cout;
            if (op_q == OP_SLT) begin
              state_q <= ST_SLT_FIX;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              dout_q  <= res_shift_d;
              cout_q  <= (op_q == OP_ADD) ? slice_cout : 1'b0;
              ovf_q   <= (op_q == OP_ADD) ? (carry_q ^ slice_cout) : 1'b0;
            end
          end
        end
        ST_SLT_FIX: begin
          cin_msb_q  <= 1'b0;
          cout_int_q <= 1'b0;
          state_q    <= ST_DONE;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          dout_q     <= res_fix_d;
          cout_q     <= 1'b0;
          ovf_q      <= 1'b0;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign dataOut       = dout_q;
  assign cout          = cout_q;
  assign overflow      = ovf_q;
  assign zero          = (dout_q == '0);
  assign slice_a       = a_sr[0];
  assign slice_b       = b_sr[0];
  assign slice_cin     = carry_q;
  assign slice_sel     = slice_op(op_q);
  assign slice_binvert = binv_q;
  assign slice_less    = 1'b0;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl at WIDTH=8 with a behavioural 1-bit slice and a word-level reference model.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         c;
    logic         o;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] inputA;
  logic [W-1:0] inputB;
  logic [1:0]   sel;
  logic         binvert;
  logic         busy;
  logic         done;
  logic [W-1:0] dataOut;
  logic         cout;
  logic         overflow;
  logic         zero;
  logic         slice_a;
  logic         slice_b;
  logic         slice_cin;
  logic [1:0]   slice_sel;
  logic         slice_binvert;
  logic         slice_less;
  logic         slice_out;
  logic         slice_cout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .inputA        (inputA),
    .inputB        (inputB),
    .sel           (sel),
    .binvert       (binvert),
    .busy          (busy),
    .done          (done),
    .dataOut       (dataOut),
    .cout          (cout),
    .overflow      (overflow),
    .zero          (zero),
    .slice_a       (slice_a),
    .slice_b       (slice_b),
    .slice_cin     (slice_cin),
    .slice_sel     (slice_sel),
    .slice_binvert (slice_binvert),
    .slice_less    (slice_less),
    .slice_out     (slice_out),
    .slice_cout    (slice_cout)
  );

  // External 1-bit ALU slice.
  logic sb;
  assign sb = slice_b ^ slice_binvert;
  assign slice_cout = (slice_a & sb) | (slice_a & slice_cin) | (sb & slice_cin);
  always_comb begin
    case (slice_sel)
      2'b00:   slice_out = slice_a & sb;
      2'b01:   slice_out = slice_a | sb;
      2'b10:   slice_out = slice_a ^ sb ^ slice_cin;
      default: slice_out = slice_less;
    endcase
  end

  // Word-level reference from the op definitions.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] s, input logic bv);
    res_t         r;
    logic         eb;
    logic [W-1:0] bm;
    logic [W:0]   sum;
    eb  = (s == 2'b11) ? 1'b1 : bv;
    bm  = eb ? ~b : b;
    sum = {1'b0, a} + {1'b0, bm} + {{W{1'b0}}, eb};
    r   = '0;
    case (s)
      2'b00: r.d = a & bm;
      2'b01: r.d = a | bm;
      2'b10: begin
        r.d = sum[W-1:0];
        r.c = sum[W];
        r.o = (a[W-1] == bm[W-1]) && (sum[W-1] != a[W-1]);
      end
      default: r.d = ($signed(a) < $signed(b)) ? {{(W-1){1'b0}}, 1'b1} : '0;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [1:0] s);
    return (s == 2'b11) ? W + 2 : W + 1;
  endfunction

  // Drives one operation and gathers what the DUT showed; junk_cyc re-asserts start with other operands.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s,
                       input logic bv, input int junk_cyc,
                       output int lat, output int ndone, output logic [W-1:0] d,
                       output logic c, output logic o, output logic z,
                       output int sel_err, output int hold_err, output logic busy1);
    logic [W-1:0] prev;
    logic [1:0]   exp_sel;
    prev    = dataOut;
    exp_sel = (s == 2'b11) ? 2'b10 : s;
    inputA  = a;
    inputB  = b;
    sel     = s;
    binvert = bv;
    start   = 1'b1;
    lat = 0; ndone = 0; d = '0; c = 1'b0; o = 1'b0; z = 1'b0;
    sel_err = 0; hold_err = 0; busy1 = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) busy1 = busy;
      if (busy === 1'b1) begin
        if (slice_sel !== exp_sel) sel_err++;
        if (dataOut !== prev) hold_err++;
      end
      if (done === 1'b1) begin
        ndone++;
        if (lat == 0) begin
          lat = cyc;
          d = dataOut; c = cout; o = overflow; z = zero;
        end
      end
      start   = (cyc == junk_cyc);
      inputA  = W'($urandom);
      inputB  = W'($urandom);
      sel     = 2'($urandom);
      binvert = 1'($urandom);
      if (lat != 0 && cyc >= lat + 1) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; inputA = '0; inputB = '0; sel = '0; binvert = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", done); end
    n_cmp++; if (dataOut !== '0) begin n_err++; $display("FAIL reset dataOut: got %h want 00", dataOut); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset cout: got %b want 0", cout); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset overflow: got %b want 0", overflow); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset zero: got %b want 1", zero); end
    n_cmp++; if (slice_less !== 1'b0) begin n_err++; $display("FAIL reset slice_less: got %b want 0", slice_less); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [7] = '{8'h7F, 8'h05, 8'h33, 8'hFD, 8'h7F, 8'hC3, 8'hC3};
    logic [W-1:0] tb [7] = '{8'h01, 8'h07, 8'h33, 8'h02, 8'hFF, 8'hA5, 8'hA5};
    logic [1:0]   ts [7] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01};
    logic         tv [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int lat, nd, se, he;
    logic [W-1:0] d;
    logic c, o, z, b1;
    res_t m;
    for (int i = 0; i < 7; i++) begin
      m = model(ta[i], tb[i], ts[i], tv[i]);
      do_op(ta[i], tb[i], ts[i], tv[i], -1, lat, nd, d, c, o, z, se, he, b1);
      n_cmp++; if (d !== m.d) begin n_err++; $display("FAIL dir%0d dataOut: got %h want %h", i, d, m.d); end
      n_cmp++; if (c !== m.c) begin n_err++; $display("FAIL dir%0d cout: got %b want %b", i, c, m.c); end
      n_cmp++; if (o !== m.o) begin n_err++; $display("FAIL dir%0d overflow: got %b want %b", i, o, m.o); end
      n_cmp++; if (z !== (m.d == '0)) begin n_err++; $display("FAIL dir%0d zero: got %b want %b", i, z, m.d == '0); end
      n_cmp++; if (lat != exp_lat(ts[i])) begin n_err++; $display("FAIL dir%0d latency: got %0d want %0d", i, lat, exp_lat(ts[i])); end
      n_cmp++; if (nd != 1) begin n_err++; $display("FAIL dir%0d done pulses: got %0d want 1", i, nd); end
      n_cmp++; if (se != 0) begin n_err++; $display("FAIL dir%0d slice_sel bad cycles: got %0d want 0", i, se); end
      n_cmp++; if (he != 0) begin n_err++; $display("FAIL dir%0d dataOut changed while busy: got %0d want 0", i, he); end
      n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL dir%0d busy after accept: got %b want 1", i, b1); end
    end
  endtask

  task automatic test_start_while_busy();
    int lat, nd, se, he;
    logic [W-1:0] d;
    logic c, o, z, b1;
    res_t m;
    m = model(8'h7F, 8'h01, 2'b10, 1'b0);
    do_op(8'h7F, 8'h01, 2'b10, 1'b0, 3, lat, nd, d, c, o, z, se, he, b1);
    n_cmp++; if (d !== m.d) begin n_err++; $display("FAIL busy_start dataOut: got %h want %h", d, m.d); end
    n_cmp++; if (nd != 1) begin n_err++; $display("FAIL busy_start done pulses: got %0d want 1", nd); end
    n_cmp++; if (lat != W + 1) begin n_err++; $display("FAIL busy_start latency: got %0d want %0d", lat, W + 1); end
    // Start held during the DONE cycle must be dropped too.
    m = model(8'h05, 8'h07, 2'b10, 1'b1);
    do_op(8'h05, 8'h07, 2'b10, 1'b1, W + 1, lat, nd, d, c, o, z, se, he, b1);
    n_cmp++; if (d !== m.d) begin n_err++; $display("FAIL done_start dataOut: got %h want %h", d, m.d); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL done_start busy: got %b want 0", busy); end
    n_cmp++; if (dataOut !== m.d) begin n_err++; $display("FAIL done_start held: got %h want %h", dataOut, m.d); end
  endtask

  task automatic test_reset_mid();
    int lat, nd, se, he, seen;
    logic [W-1:0] d;
    logic c, o, z, b1;
    res_t m;
    do_op(8'hC3, 8'hA5, 2'b00, 1'b0, -1, lat, nd, d, c, o, z, se, he, b1);
    inputA = 8'h7F; inputB = 8'h01; sel = 2'b10; binvert = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst done: got %b want 0", done); end
    n_cmp++; if (dataOut !== '0) begin n_err++; $display("FAIL midrst dataOut: got %h want 00", dataOut); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL midrst zero: got %b want 1", zero); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midrst activity after abort: got %0d cycles want 0", seen); end
    m = model(8'h12, 8'h34, 2'b10, 1'b0);
    do_op(8'h12, 8'h34, 2'b10, 1'b0, -1, lat, nd, d, c, o, z, se, he, b1);
    n_cmp++; if (d !== m.d) begin n_err++; $display("FAIL midrst recover dataOut: got %h want %h", d, m.d); end
    n_cmp++; if (lat != W + 1) begin n_err++; $display("FAIL midrst recover latency: got %0d want %0d", lat, W + 1); end
  endtask

  task automatic test_random();
    int lat, nd, se, he;
    logic [W-1:0] a, b, d;
    logic [1:0] s;
    logic bv, c, o, z, b1;
    res_t m;
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom); b = W'($urandom); s = 2'($urandom); bv = 1'($urandom);
      if (i % 7 == 0) b = a;
      m = model(a, b, s, bv);
      do_op(a, b, s, bv, -1, lat, nd, d, c, o, z, se, he, b1);
      n_cmp++; if ({d, c, o} !== {m.d, m.c, m.o}) begin
        n_err++; $display("FAIL rand%0d a=%h b=%h sel=%b bv=%b: got d=%h c=%b o=%b want d=%h c=%b o=%b",
                          i, a, b, s, bv, d, c, o, m.d, m.c, m.o);
      end
      n_cmp++; if (z !== (m.d == '0)) begin n_err++; $display("FAIL rand%0d zero: got %b want %b", i, z, m.d == '0); end
      n_cmp++; if (lat != exp_lat(s) || nd != 1) begin
        n_err++; $display("FAIL rand%0d timing: got lat=%0d pulses=%0d want lat=%0d pulses=1", i, lat, nd, exp_lat(s));
      end
      n_cmp++; if (se != 0 || he != 0) begin
        n_err++; $display("FAIL rand%0d run-phase: got sel_err=%0d hold_err=%0d want 0/0", i, se, he);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
